ex_alu_iter: RTL and testbench



---
 rtl/ex_alu_iter.sv | 172 +++++++++++++++++
 tb/tb_ex_alu_iter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ex_alu_iter.sv
// Execute-stage ALU with valid/ready handshakes; shifts step one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module ex_alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [1:0]      dbg_state_o
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Handshake: an op is accepted when in_valid && in_ready at a rising edge;
  // a result is consumed when out_valid && out_ready at a rising edge.
  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   alu_res;
  logic              op_illegal;
  logic              go_shift;
`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]   work_q, work_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        sop_q, sop_d;
  logic [XLEN-1:0]   shifted;
`endif

  assign op_illegal = (op > OP_PASSB);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_PASSB: alu_res = b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:   alu_res = a << b[4:0];
      OP_SRL:   alu_res = a >> b[4:0];
      OP_SRA:   alu_res = $signed(a) >>> b[4:0];
`else
      // Only reached for a zero shift count; longer shifts go through S_SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`endif
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = ((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA)) && (b[4:0] != 5'd0);

  always_comb begin
    case (sop_q)
      OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
      OP_SRA:  shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: shifted = {1'b0, work_q[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    work_d    = work_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (go_shift) begin
`ifndef ALU_FAST_SHIFT_EN
            work_d  = a;
            cnt_d   = b[4:0];
            sop_d   = op;
`endif
            state_d = S_SHIFT;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = op_illegal;
            state_d   = S_DONE;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d  = shifted;
          zero_d    = (shifted == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      work_q    <= '0;
      cnt_q     <= 5'd0;
      sop_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      sop_q     <= sop_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_alu_iter.sv
// Randomized self-checking bench for ex_alu_iter against a plain-arithmetic reference model.
module tb_ex_alu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ex_alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int unsigned k;
    k = y[4:0];
    case (o)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:    return (x < y) ? 32'd1 : 32'd0;
      4'd7:    return x << k;
      4'd8:    return x >> k;
      4'd9:    return $unsigned($signed(x) >>> k);
      4'd10:   return y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [31:0] y);
`ifdef ALU_FAST_SHIFT_EN
    return 0;
`else
    return (o >= 4'd7 && o <= 4'd9) ? int'(y[4:0]) : 0;
`endif
  endfunction

  // Edges after the accept edge before out_valid is seen; stall = DONE cycles held with out_ready low.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit keep_ready, input int stall);
    logic [31:0] want;
    int cyc;
    exp_q.push_back(model(o, x, y));
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    out_ready = keep_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check("busy_no_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, model_lat(o, y));
    want = exp_q.pop_front();
    check("result", result, want);
    check("zero", {31'd0, zero}, {31'd0, (want == 32'd0)});
    check("illegal", {31'd0, illegal}, {31'd0, (o > 4'd10)});
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    if (!keep_ready) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", result, want);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_result", result, want);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    run_op(4'd0, 32'd5, 32'd7, 1'b1, 0);
    run_op(4'd1, 32'h3, 32'h3, 1'b0, 0);
    run_op(4'd5, 32'hFFFFFFFF, 32'h1, 1'b0, 0);
    run_op(4'd6, 32'hFFFFFFFF, 32'h1, 1'b0, 0);
    run_op(4'd9, 32'h80000000, 32'd4, 1'b0, 0);
    run_op(4'd10, 32'h0, 32'hABCD, 1'b0, 3);
    run_op(4'd15, 32'h1234, 32'h1, 1'b0, 1);
    run_op(4'd0, 32'h1, 32'h1, 1'b0, 0);
    run_op(4'd7, 32'h1, 32'd31, 1'b0, 0);
    run_op(4'd8, 32'hF0F0F0F0, 32'hFFFFFFE0, 1'b1, 0);
    run_op(4'd9, 32'h7FFFFFFF, 32'd31, 1'b0, 0);
    run_op(4'd0, 32'h1111, 32'h2222, 1'b0, 0);

    // Reset mid-shift: SLL 1 by 31, rst sampled at the tenth edge after accept.
    op = 4'd7; a = 32'h1; b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) rb = {27'($urandom), 5'($urandom_range(0, 2))};
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
